// File: rtl/alu_req_arbiter.sv
// Two-requester front end for a shared, fixed-latency ALU.
// Requests are granted round-robin, and each grant drives the ALU inputs in
// the same cycle. A tag pipe of LAT stages carries the grant id, so each
// result returns to its owner exactly LAT cycles later. The pipe never stalls.
module alu_req_arbiter #(
    parameter int LAT = 1,
    parameter int W   = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         req0_valid,
    input  logic         req1_valid,
    output logic         req0_ready,
    output logic         req1_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic [1:0]   req0_op,
    input  logic [1:0]   req1_op,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [1:0]   alu_op,
    input  logic [W-1:0] alu_y,
    output logic         rsp0_valid,
    output logic         rsp1_valid,
    output logic [W-1:0] rsp_y,
    output logic [2:0]   inflight,
    output logic [15:0]  gnt_cnt0,
    output logic [15:0]  gnt_cnt1
);

    // rr_q == 0 means requester 0 wins the next contended cycle
    logic           rr_q, rr_d;
    logic [LAT-1:0] tag_vld_q, tag_vld_d;
    logic [LAT-1:0] tag_id_q, tag_id_d;
    logic [2:0]     inflight_q, inflight_d;
    logic [15:0]    gnt_cnt0_q, gnt_cnt0_d;
    logic [15:0]    gnt_cnt1_q, gnt_cnt1_d;

    logic gnt0, gnt1, issue, rsp_vld;

    // Arbitration: a single valid wins outright, and contention is settled by rr
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst && en) begin
            if (req0_valid && req1_valid) begin
                gnt0 = ~rr_q;
                gnt1 = rr_q;
            end else begin
                gnt0 = req0_valid;
                gnt1 = req1_valid;
            end
        end
    end

    assign issue      = gnt0 | gnt1;
    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    // ALU input mux: the granted operands, or all-zero when idle so the ALU sees no stray activity
    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = 2'b00;
        if (gnt0) begin
            alu_a  = req0_a;
            alu_b  = req0_b;
            alu_op = req0_op;
        end else if (gnt1) begin
            alu_a  = req1_a;
            alu_b  = req1_b;
            alu_op = req1_op;
        end
    end

    // Response steering: the last tag stage lines up with alu_y for the op it tracks
    assign rsp_vld    = tag_vld_q[LAT-1] & ~rst;
    assign rsp0_valid = rsp_vld & ~tag_id_q[LAT-1];
    assign rsp1_valid = rsp_vld & tag_id_q[LAT-1];
    assign rsp_y      = rsp_vld ? alu_y : '0;

    // Next-state for the tag pipe, rr pointer, occupancy and grant counters
    always_comb begin
        tag_vld_d    = tag_vld_q;
        tag_id_d     = tag_id_q;
        tag_vld_d[0] = issue;
        tag_id_d[0]  = gnt1;
        for (int i = 1; i < LAT; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_id_d[i]  = tag_id_q[i-1];
        end

        rr_d = rr_q;
        if (gnt0) begin
            rr_d = 1'b1;
        end else if (gnt1) begin
            rr_d = 1'b0;
        end

        inflight_d = inflight_q;
        case ({issue, rsp_vld})
            2'b10:   inflight_d = inflight_q + 3'd1;
            2'b01:   inflight_d = inflight_q - 3'd1;
            default: inflight_d = inflight_q;
        endcase

        gnt_cnt0_d = gnt_cnt0_q + {15'd0, gnt0};
        gnt_cnt1_d = gnt_cnt1_q + {15'd0, gnt1};
    end

    // Control state: reset flushes every in-flight tag so discarded ops never respond
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_vld_q  <= '0;
            rr_q       <= 1'b0;
            inflight_q <= 3'd0;
            gnt_cnt0_q <= 16'd0;
            gnt_cnt1_q <= 16'd0;
        end else begin
            tag_vld_q  <= tag_vld_d;
            rr_q       <= rr_d;
            inflight_q <= inflight_d;
            gnt_cnt0_q <= gnt_cnt0_d;
            gnt_cnt1_q <= gnt_cnt1_d;
        end
    end

    // Tag ids are qualified by tag_vld_q, so they need no reset
    always_ff @(posedge clk) begin
        tag_id_q <= tag_id_d;
    end

    assign inflight = inflight_q;
    assign gnt_cnt0 = gnt_cnt0_q;
    assign gnt_cnt1 = gnt_cnt1_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Testbench for alu_req_arbiter. Two instances (LAT=1 and LAT=3) share one
// stimulus, and each one has its own external ALU model. Every directed step
// states the grant and result it expects. A negedge monitor matches the
// responses against per-instance expectation queues.
module tb_alu_req_arbiter;

    localparam logic [1:0] ADD = 2'd0, SUB = 2'd1, AND_ = 2'd2, OR_ = 2'd3;

    typedef struct {
        logic       id;
        logic [7:0] y;
        int         due;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [7:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [1:0] req0_op = '0, req1_op = '0;

    logic       u1_r0, u1_r1, u1_v0, u1_v1, u3_r0, u3_r1, u3_v0, u3_v1;
    logic [7:0] u1_a, u1_b, u1_y, u1_ry, u3_a, u3_b, u3_y, u3_ry;
    logic [1:0] u1_op, u3_op;
    logic [2:0] u1_inf, u3_inf;
    logic [15:0] u1_c0, u1_c1, u3_c0, u3_c1;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q1[$];
    exp_t q3[$];
    logic [15:0] cnt0_exp = '0, cnt1_exp = '0;
    logic [7:0]  p3 [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_req_arbiter #(.LAT(1), .W(8)) u_lat1 (
        .clk(clk), .rst(rst), .en(en),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(u1_r0), .req1_ready(u1_r1),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_op(req0_op), .req1_op(req1_op),
        .alu_a(u1_a), .alu_b(u1_b), .alu_op(u1_op), .alu_y(u1_y),
        .rsp0_valid(u1_v0), .rsp1_valid(u1_v1), .rsp_y(u1_ry),
        .inflight(u1_inf), .gnt_cnt0(u1_c0), .gnt_cnt1(u1_c1)
    );

    alu_req_arbiter #(.LAT(3), .W(8)) u_lat3 (
        .clk(clk), .rst(rst), .en(en),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(u3_r0), .req1_ready(u3_r1),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_op(req0_op), .req1_op(req1_op),
        .alu_a(u3_a), .alu_b(u3_b), .alu_op(u3_op), .alu_y(u3_y),
        .rsp0_valid(u3_v0), .rsp1_valid(u3_v1), .rsp_y(u3_ry),
        .inflight(u3_inf), .gnt_cnt0(u3_c0), .gnt_cnt1(u3_c1)
    );

    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        case (op)
            ADD:     return a + b;
            SUB:     return a - b;
            AND_:    return a & b;
            default: return a | b;
        endcase
    endfunction

    // External ALUs: one registered stage and three registered stages
    always @(posedge clk) begin
        u1_y  <= alu_f(u1_a, u1_b, u1_op);
        p3[0] <= alu_f(u3_a, u3_b, u3_op);
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign u3_y = p3[2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    // Response monitor: pops the expectation due this cycle, else requires silence
    always @(negedge clk) begin
        exp_t e;
        logic [9:0] ex;
        ex = '0;
        if (q1.size() > 0 && q1[0].due == cyc) begin
            e  = q1.pop_front();
            ex = {e.id, ~e.id, e.y};
        end
        chk("rsp_lat1 {v1,v0,y}", {22'd0, u1_v1, u1_v0, u1_ry}, {22'd0, ex});
        ex = '0;
        if (q3.size() > 0 && q3[0].due == cyc) begin
            e  = q3.pop_front();
            ex = {e.id, ~e.id, e.y};
        end
        chk("rsp_lat3 {v1,v0,y}", {22'd0, u3_v1, u3_v0, u3_ry}, {22'd0, ex});
    end

    // One cycle of stimulus: g = 0 none, 1 req0, 2 req1; y = hand-computed result
    task automatic step(input logic e, input logic v0, input logic [1:0] o0, input logic [7:0] a0,
                        input logic [7:0] b0, input logic v1, input logic [1:0] o1,
                        input logic [7:0] a1, input logic [7:0] b1, input int g, input logic [7:0] y);
        exp_t ent;
        logic [17:0] ealu;
        logic [1:0]  erdy;
        en = e; req0_valid = v0; req0_op = o0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_op = o1; req1_a = a1; req1_b = b1;
        #2;
        erdy = (g == 1) ? 2'b01 : (g == 2) ? 2'b10 : 2'b00;
        ealu = (g == 1) ? {a0, b0, o0} : (g == 2) ? {a1, b1, o1} : 18'd0;
        chk("ready_lat1 {r1,r0}", {30'd0, u1_r1, u1_r0}, {30'd0, erdy});
        chk("ready_lat3 {r1,r0}", {30'd0, u3_r1, u3_r0}, {30'd0, erdy});
        chk("alu_lat1 {a,b,op}", {14'd0, u1_a, u1_b, u1_op}, {14'd0, ealu});
        chk("alu_lat3 {a,b,op}", {14'd0, u3_a, u3_b, u3_op}, {14'd0, ealu});
        chk("inflight_lat1", {29'd0, u1_inf}, q1.size());
        chk("inflight_lat3", {29'd0, u3_inf}, q3.size());
        chk("gnt_cnt0", {u3_c0, u1_c0}, {cnt0_exp, cnt0_exp});
        chk("gnt_cnt1", {u3_c1, u1_c1}, {cnt1_exp, cnt1_exp});
        if (g != 0) begin
            ent.id  = (g == 2);
            ent.y   = y;
            ent.due = cyc + 1;
            q1.push_back(ent);
            ent.due = cyc + 3;
            q3.push_back(ent);
            if (g == 1) cnt0_exp = cnt0_exp + 16'd1;
            else        cnt1_exp = cnt1_exp + 16'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b1, 1'b0, ADD, 8'h00, 8'h00, 1'b0, ADD, 8'h00, 8'h00, 0, 8'h00);
    endtask

    // Reset with both requesters asking: nothing may be granted or driven
    task automatic do_reset(input int n);
        rst = 1'b1; en = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = 8'h11; req0_b = 8'h22; req1_a = 8'h33; req1_b = 8'h44;
        q1.delete(); q3.delete();
        cnt0_exp = '0; cnt1_exp = '0;
        repeat (n) begin
            #2;
            chk("rst_ready {u3r1,u3r0,u1r1,u1r0}", {28'd0, u3_r1, u3_r0, u1_r1, u1_r0}, 32'd0);
            chk("rst_alu_lat1", {14'd0, u1_a, u1_b, u1_op}, 32'd0);
            chk("rst_alu_lat3", {14'd0, u3_a, u3_b, u3_op}, 32'd0);
            @(posedge clk);
            #1;
        end
        rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    initial begin
        do_reset(2);
        idle(1);

        // single add on requester 0
        step(1, 1, ADD, 8'd10, 8'd5, 0, ADD, 8'h00, 8'h00, 1, 8'd15);
        idle(3);

        // contention straight after reset: alternating 0,1,0,1
        do_reset(1);
        repeat (2) begin
            step(1, 1, SUB, 8'd20, 8'd7, 1, AND_, 8'hAA, 8'hCC, 1, 8'd13);
            step(1, 1, SUB, 8'd20, 8'd7, 1, AND_, 8'hAA, 8'hCC, 2, 8'h88);
        end

        // lone requesters then contention: after req1 alone, req0 wins first
        step(1, 1, ADD, 8'hFF, 8'h01, 0, OR_, 8'hAA, 8'hCC, 1, 8'h00);
        step(1, 0, ADD, 8'hFF, 8'h01, 1, OR_, 8'hAA, 8'hCC, 2, 8'hEE);
        step(1, 1, SUB, 8'd5, 8'd10, 1, OR_, 8'hAA, 8'hCC, 1, 8'hFB);
        step(1, 1, SUB, 8'd5, 8'd10, 1, OR_, 8'hAA, 8'hCC, 2, 8'hEE);

        // en low with both valid: no grants, pending responses still arrive
        repeat (3) step(0, 1, SUB, 8'd5, 8'd10, 1, OR_, 8'hAA, 8'hCC, 0, 8'h00);
        step(1, 1, SUB, 8'd5, 8'd10, 1, OR_, 8'hAA, 8'hCC, 1, 8'hFB);
        step(1, 1, SUB, 8'd5, 8'd10, 1, OR_, 8'hAA, 8'hCC, 2, 8'hEE);

        // requester 1 withdraws before being accepted
        step(0, 0, ADD, 8'h00, 8'h00, 1, ADD, 8'h01, 8'h01, 0, 8'h00);
        step(1, 0, ADD, 8'h00, 8'h00, 0, ADD, 8'h01, 8'h01, 0, 8'h00);

        // four back-to-back ops, LAT=3 instance reaches three in flight
        step(1, 1, ADD, 8'h12, 8'h34, 1, SUB, 8'h10, 8'h20, 1, 8'h46);
        step(1, 1, AND_, 8'hF0, 8'h3C, 1, SUB, 8'h10, 8'h20, 2, 8'hF0);
        step(1, 1, AND_, 8'hF0, 8'h3C, 1, OR_, 8'h0F, 8'h50, 1, 8'h30);
        step(1, 0, AND_, 8'hF0, 8'h3C, 1, OR_, 8'h0F, 8'h50, 2, 8'h5F);
        idle(4);

        // drive gnt_cnt0 to 0xFFFF, then one more grant wraps it to 0x0000
        while (cnt0_exp != 16'hFFFF) begin
            step(1, 1, ADD, cnt0_exp[7:0], 8'h01, 0, ADD, 8'h00, 8'h00, 1, cnt0_exp[7:0] + 8'h01);
        end
        step(1, 1, OR_, 8'h0F, 8'hF0, 0, ADD, 8'h00, 8'h00, 1, 8'hFF);
        idle(4);

        // reset with two ops in flight: they must never respond
        step(1, 1, ADD, 8'd1, 8'd2, 0, ADD, 8'd3, 8'd4, 1, 8'd3);
        step(1, 0, ADD, 8'd1, 8'd2, 1, ADD, 8'd3, 8'd4, 2, 8'd7);
        do_reset(2);
        idle(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_req_arbiter.md
ALU_REQ_ARBITER -- requirements
Module: alu_req_arbiter

Interface
REQ-001 Parameter LAT, default 1, SHALL set the ALU pipeline latency in cycles (legal 1..4); 1 matches the existing registered-output ALU.
REQ-002 Parameter W, default 8, SHALL set the operand/result width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-005 en  input  1  SHALL enable new grants; when low, no grant is issued and in-flight ops drain.
REQ-006 req0_valid, req1_valid  input  1 each  SHALL indicate requester 0/1 presents an operation.
REQ-007 req0_ready, req1_ready  output  1 each  SHALL indicate the requester's operation is accepted this cycle.
REQ-008 req0_a, req0_b, req1_a, req1_b  input  W each  SHALL be operands A/B per requester.
REQ-009 req0_op, req1_op  input  2 each  SHALL be the opcode per requester (00 add, 01 sub, 10 and, 11 or).
REQ-010 alu_a, alu_b  output  W each; alu_op  output  2  SHALL drive the shared ALU inputs.
REQ-011 alu_y  input  W  SHALL be the shared ALU result.
REQ-012 rsp0_valid, rsp1_valid  output  1 each  SHALL pulse when that requester's result is on rsp_y.
REQ-013 rsp_y  output  W  SHALL carry the result for the asserted rsp*_valid.
REQ-014 inflight  output  3  SHALL count issued ops whose response has not yet been delivered.
REQ-015 gnt_cnt0, gnt_cnt1  output  16 each  SHALL count accepted ops per requester.

Function
REQ-016 Transfer SHALL occur on reqN_valid & reqN_ready in the same cycle; requesters hold operands/opcode stable while valid & !ready.
REQ-017 At most one ready SHALL be high per cycle; ready is combinational from valids, en and rr pointer; ready never depends on alu_y.
REQ-018 Arbitration: en low -> no grant; exactly one valid -> grant it; both valid -> grant requester indicated by rr.
REQ-019 rr (1 bit) SHALL update after each grant to point at the non-granted requester; unchanged when no grant.
REQ-020 alu_a/alu_b/alu_op SHALL equal the granted requester's inputs in the grant cycle, and all-zero when no grant.
REQ-021 A tag pipe of LAT stages (valid + id) SHALL be loaded at the grant edge and shifted every cycle unconditionally (no backpressure).
REQ-022 Op granted in cycle t SHALL produce rspN_valid=1 for exactly cycle t+LAT, with rsp_y=alu_y in that cycle; rsp_y=0 when no rsp*_valid.
REQ-023 rsp0_valid and rsp1_valid SHALL never be high together; throughput SHALL be one op per cycle sustained.
REQ-024 inflight SHALL increment on grant, decrement on response, stay unchanged on simultaneous grant+response; range 0..LAT.
REQ-025 gnt_cnt0/1 SHALL increment by one per accepted op and wrap 0xFFFF -> 0x0000.
REQ-026 Deasserting en SHALL not cancel in-flight ops; their responses are delivered at the normal cycle.
REQ-027 A requester dropping valid before ready SHALL be legal and SHALL not be granted or counted.

Reset
REQ-028 With rst high at a clock edge: tag pipe cleared, rr=0 (requester 0 first), inflight=0, gnt_cnt0/1=0.
REQ-029 During and the cycle after reset: req*_ready=0 while rst high, rsp*_valid=0, rsp_y=0, alu_* =0.
REQ-030 Reset mid-operation SHALL discard all in-flight ops; no response for them is ever emitted.

Verification
REQ-031 Single op: req0 add 10,5, LAT=1 -> req0_ready=1 cycle t, rsp0_valid=1 cycle t+1, rsp_y=15, inflight 1 then 0.
REQ-032 Contention: both valid continuously after reset, req0 sub 20,7, req1 and 0xAA,0xCC -> grants alternate 0,1,0,1; responses 13, 0x88 alternate one cycle later.
REQ-033 Idle gap: req1 alone (or 0xAA,0xCC) then both valid -> req0 granted first (rr points away from 1); result 0xEE on rsp1.
REQ-034 en low for 3 cycles with both valid -> no ready, no alu activity, pending responses still delivered; grants resume when en=1.
REQ-035 LAT=3 back-to-back 4 ops -> each response exactly 3 cycles after grant, inflight peaks at 3.
REQ-036 rst asserted with 2 ops in flight -> no rsp*_valid afterward, inflight=0, gnt_cnt0/1=0; counter wrap checked by forcing 0xFFFF grants -> 0x0000.
